// File: rtl/edge_pkg.sv
// Shared types and helpers for the gradient-magnitude engine.
// Consumers: edge_mag_engine (build option EDGE_ABS_APPROX_EN selects |gx|+|gy| instead of sqrt).
package edge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_SQRT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [2:0] OP_GRAD = 3'b111;

  // matrix_size code 0..3 maps to window dimension 2..5
  function automatic logic [2:0] size_to_n(input logic [1:0] sz);
    return 3'(sz) + 3'd2;
  endfunction

  // bit offset of element (r,c) in a row-major packed matrix bus
  function automatic int unsigned elem_base(input int unsigned r, input int unsigned c,
                                            input int unsigned max_n, input int unsigned data_w);
    return (r * max_n + c) * data_w;
  endfunction

endpackage

// File: rtl/edge_mag_engine_if.sv
// Request/response bundle between the register-file bridge and the gradient-magnitude engine.
interface edge_mag_engine_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MAX_N  = 5,
  parameter int unsigned ACC_W  = 20,
  parameter int unsigned OUT_W  = 8
);
  localparam int unsigned MAT_W = MAX_N * MAX_N * DATA_W;

  logic             start;
  logic [2:0]       op_code;
  logic [1:0]       matrix_size;
  logic [MAT_W-1:0] matrix_a;
  logic [MAT_W-1:0] matrix_b;
  logic [MAT_W-1:0] matrix_c;
  logic             busy;
  logic             done;
  logic             op_err;
  logic [OUT_W-1:0] result;
  logic [ACC_W:0]   mag_raw;

  modport master (
    output start, op_code, matrix_size, matrix_a, matrix_b, matrix_c,
    input  busy, done, op_err, result, mag_raw
  );

  modport slave (
    input  start, op_code, matrix_size, matrix_a, matrix_b, matrix_c,
    output busy, done, op_err, result, mag_raw
  );

endinterface

// File: rtl/isqrt_seq.sv
// Restoring integer square root, one root bit per cycle; start performs the first iteration.
// done pulses the cycle after the final iteration with root = floor(sqrt(radicand)).
module isqrt_seq #(
  parameter  int unsigned W  = 41,
  localparam int unsigned RT = W / 2 + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  radicand,
  output logic          done,
  output logic [RT-1:0] root
);

  localparam int unsigned PW = 2 * RT;
  localparam int unsigned CW = $clog2(RT);

  logic [PW-1:0] rad_q;
  logic [RT-1:0] rem_q;
  logic [CW-1:0] cnt_q;
  logic          active_q;

  logic [PW-1:0] rad_cur;
  logic [RT-1:0] rem_cur;
  logic [RT-2:0] root_cur;
  logic [RT+1:0] rem_t;
  logic [RT+1:0] trial;
  logic          fits;
  logic [RT-1:0] rem_nxt;
  logic [RT-1:0] root_nxt;

  // one restoring step on the top two radicand bits
  always_comb begin
    rad_cur  = start ? PW'(radicand) : rad_q;
    rem_cur  = start ? '0 : rem_q;
    root_cur = start ? '0 : root[RT-2:0];
    rem_t    = {rem_cur, rad_cur[PW-1 -: 2]};
    trial    = {1'b0, root_cur, 2'b01};
    fits     = (rem_t >= trial);
    rem_nxt  = fits ? RT'(rem_t - trial) : RT'(rem_t);
    root_nxt = {root_cur, fits};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rad_q    <= '0;
      rem_q    <= '0;
      root     <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start || active_q) begin
        rad_q <= {rad_cur[PW-3:0], 2'b00};
        rem_q <= rem_nxt;
        root  <= root_nxt;
        if (start) begin
          cnt_q    <= CW'(RT - 1);
          active_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            active_q <= 1'b0;
            done     <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/edge_mag_engine.sv
// Gradient-magnitude coprocessor: NxN Gx/Gy MAC scan, then floor sqrt, saturated to a pixel.
// Build option EDGE_ABS_APPROX_EN replaces the sqrt with |gx|+|gy| and skips the SQRT state.
module edge_mag_engine
  import edge_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MAX_N  = 5,
  parameter int unsigned ACC_W  = 20,
  parameter int unsigned OUT_W  = 8
) (
  input logic              clk,
  input logic              reset,
  edge_mag_engine_if.slave bus
);

  localparam int unsigned MAT_W = MAX_N * MAX_N * DATA_W;
  localparam int unsigned IW    = $clog2(MAT_W);
  localparam int unsigned PRD_W = 2 * DATA_W;
  localparam int unsigned MAG_W = ACC_W + 1;

  state_t                   state;
  logic [2:0]               n_q;
  logic [2:0]               r_q;
  logic [2:0]               c_q;
  logic [MAT_W-1:0]         mat_a_q;
  logic [MAT_W-1:0]         mat_b_q;
  logic [MAT_W-1:0]         mat_c_q;
  logic signed [ACC_W-1:0]  gx_q;
  logic signed [ACC_W-1:0]  gy_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     op_err_q;
  logic [OUT_W-1:0]         result_q;
  logic [MAG_W-1:0]         mag_q;

  logic [IW-1:0]            base;
  logic signed [DATA_W-1:0] ea;
  logic signed [DATA_W-1:0] eb;
  logic signed [DATA_W-1:0] ec;
  logic signed [PRD_W-1:0]  pb;
  logic signed [PRD_W-1:0]  pc;
  logic signed [ACC_W-1:0]  gx_nxt;
  logic signed [ACC_W-1:0]  gy_nxt;
  logic                     last;

  function automatic logic [OUT_W-1:0] sat(input logic [MAG_W-1:0] m);
    return (m > MAG_W'(2 ** OUT_W - 1)) ? '1 : m[OUT_W-1:0];
  endfunction

  // current element products and next accumulator values
  always_comb begin
    base   = IW'(elem_base(32'(r_q), 32'(c_q), MAX_N, DATA_W));
    ea     = mat_a_q[base +: DATA_W];
    eb     = mat_b_q[base +: DATA_W];
    ec     = mat_c_q[base +: DATA_W];
    pb     = ea * eb;
    pc     = ea * ec;
    gx_nxt = gx_q + {{(ACC_W - PRD_W){pb[PRD_W-1]}}, pb};
    gy_nxt = gy_q + {{(ACC_W - PRD_W){pc[PRD_W-1]}}, pc};
    last   = (r_q == n_q - 3'd1) && (c_q == n_q - 3'd1);
  end

`ifdef EDGE_ABS_APPROX_EN
  logic [MAG_W-1:0] abs_gx;
  logic [MAG_W-1:0] abs_gy;
  logic [MAG_W-1:0] abs_sum;

  // one extra bit keeps |-2^(ACC_W-1)| representable
  always_comb begin
    abs_gx  = gx_nxt[ACC_W-1] ? -{gx_nxt[ACC_W-1], gx_nxt} : {gx_nxt[ACC_W-1], gx_nxt};
    abs_gy  = gy_nxt[ACC_W-1] ? -{gy_nxt[ACC_W-1], gy_nxt} : {gy_nxt[ACC_W-1], gy_nxt};
    abs_sum = abs_gx + abs_gy;
  end
`else
  localparam int unsigned SQ_W = 2 * ACC_W + 1;

  logic signed [2*ACC_W-1:0] gx_sq;
  logic signed [2*ACC_W-1:0] gy_sq;
  logic [SQ_W-1:0]           radicand;
  logic                      sq_start;
  logic                      sq_done;
  logic [MAG_W-1:0]          sq_root;

  // sqrt launches on the final MAC cycle so its first iteration overlaps the last accumulate
  always_comb begin
    gx_sq    = gx_nxt * gx_nxt;
    gy_sq    = gy_nxt * gy_nxt;
    radicand = {1'b0, gx_sq} + {1'b0, gy_sq};
    sq_start = (state == ST_MAC) && last;
  end

  isqrt_seq #(.W(SQ_W)) u_isqrt (
    .clk      (clk),
    .reset    (reset),
    .start    (sq_start),
    .radicand (radicand),
    .done     (sq_done),
    .root     (sq_root)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      n_q      <= '0;
      r_q      <= '0;
      c_q      <= '0;
      mat_a_q  <= '0;
      mat_b_q  <= '0;
      mat_c_q  <= '0;
      gx_q     <= '0;
      gy_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      op_err_q <= 1'b0;
      result_q <= '0;
      mag_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            n_q     <= size_to_n(bus.matrix_size);
            r_q     <= '0;
            c_q     <= '0;
            mat_a_q <= bus.matrix_a;
            mat_b_q <= bus.matrix_b;
            mat_c_q <= bus.matrix_c;
            gx_q    <= '0;
            gy_q    <= '0;
            busy_q  <= 1'b1;
            if (bus.op_code == OP_GRAD) begin
              state <= ST_MAC;
            end else begin
              state    <= ST_DONE;
              done_q   <= 1'b1;
              op_err_q <= 1'b1;
              result_q <= '0;
              mag_q    <= '0;
            end
          end
        end
        ST_MAC: begin
          gx_q <= gx_nxt;
          gy_q <= gy_nxt;
          if (last) begin
`ifdef EDGE_ABS_APPROX_EN
            state    <= ST_DONE;
            done_q   <= 1'b1;
            op_err_q <= 1'b0;
            mag_q    <= abs_sum;
            result_q <= sat(abs_sum);
`else
            state <= ST_SQRT;
`endif
          end else if (c_q == n_q - 3'd1) begin
            c_q <= '0;
            r_q <= r_q + 3'd1;
          end else begin
            c_q <= c_q + 3'd1;
          end
        end
        ST_SQRT: begin
`ifdef EDGE_ABS_APPROX_EN
          state  <= ST_IDLE;
          busy_q <= 1'b0;
`else
          if (sq_done) begin
            state    <= ST_DONE;
            done_q   <= 1'b1;
            op_err_q <= 1'b0;
            mag_q    <= sq_root;
            result_q <= sat(sq_root);
          end
`endif
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.op_err  = op_err_q;
  assign bus.result  = result_q;
  assign bus.mag_raw = mag_q;

endmodule

// File: tb/tb_edge_mag_engine.sv
// Directed bench for edge_mag_engine with hand-computed expectations (EDGE_ABS_APPROX_EN aware).
module tb_edge_mag_engine;
  import edge_pkg::*;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned MAX_N  = 5;
  localparam int unsigned ACC_W  = 20;
  localparam int unsigned OUT_W  = 8;
`ifdef EDGE_ABS_APPROX_EN
  localparam int SQ_LAT = 0;
  localparam int T1_MAG = 7;
`else
  localparam int SQ_LAT = 21;
  localparam int T1_MAG = 5;
`endif

  logic clk = 1'b0;
  logic reset;
  int   cyc   = 0;
  int   t0    = 0;
  int   total = 0;
  int   bad   = 0;
  int   lat;
  int   seen;
  int   sx [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  int   sy [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

  edge_mag_engine_if #(.DATA_W(DATA_W), .MAX_N(MAX_N), .ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

  edge_mag_engine #(.DATA_W(DATA_W), .MAX_N(MAX_N), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mats();
    bus.matrix_a = '0;
    bus.matrix_b = '0;
    bus.matrix_c = '0;
  endtask

  task automatic set_el(input int m, input int r, input int c, input int v);
    logic [9:0] idx;
    idx = 10'((r * int'(MAX_N) + c) * int'(DATA_W));
    case (m)
      0:       bus.matrix_a[idx +: 8] = 8'(v);
      1:       bus.matrix_b[idx +: 8] = 8'(v);
      default: bus.matrix_c[idx +: 8] = 8'(v);
    endcase
  endtask

  task automatic setup_t1();
    clear_mats();
    set_el(0, 0, 0, 1);
    set_el(1, 0, 0, 3);
    set_el(2, 0, 0, 4);
  endtask

  task automatic setup_sobel();
    clear_mats();
    for (int i = 0; i < 9; i++) begin
      set_el(1, i / 3, i % 3, sx[i]);
      set_el(2, i / 3, i % 3, sy[i]);
    end
    for (int r = 0; r < 3; r++) set_el(0, r, 2, 10);
  endtask

  task automatic setup_extreme();
    clear_mats();
    for (int i = 0; i < 25; i++) begin
      set_el(0, i / 5, i % 5, -128);
      set_el(1, i / 5, i % 5, 127);
    end
  endtask

  task automatic launch(input logic [2:0] op, input logic [1:0] sz);
    tick();
    bus.op_code     = op;
    bus.matrix_size = sz;
    bus.start       = 1'b1;
    @(posedge clk);
    #1;
    t0        = cyc;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int l);
    while (bus.done !== 1'b1 && (cyc - t0) < 300) tick();
    l = (bus.done === 1'b1) ? (cyc - t0 + 1) : -1;
  endtask

  initial begin
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.op_code     = OP_GRAD;
    bus.matrix_size = 2'b00;
    clear_mats();
    tick(3);
    reset = 1'b0;
    tick();
    chk("rst_busy",   32'(bus.busy),    0);
    chk("rst_done",   32'(bus.done),    0);
    chk("rst_op_err", 32'(bus.op_err),  0);
    chk("rst_result", 32'(bus.result),  0);
    chk("rst_mag",    32'(bus.mag_raw), 0);

    // 2x2: gx=3, gy=4
    setup_t1();
    launch(OP_GRAD, 2'b00);
    wait_done(lat);
    chk("t1_lat",    32'(lat),         32'(1 + 4 + SQ_LAT));
    chk("t1_mag",    32'(bus.mag_raw), 32'(T1_MAG));
    chk("t1_result", 32'(bus.result),  32'(T1_MAG));
    chk("t1_op_err", 32'(bus.op_err),  0);
    chk("t1_busy",   32'(bus.busy),    1);
    tick();
    chk("t1_pulse",  32'(bus.done),    0);
    chk("t1_idle",   32'(bus.busy),    0);

    // 3x3 Sobel on a vertical line: gx=40, gy=0
    setup_sobel();
    launch(OP_GRAD, 2'b01);
    wait_done(lat);
    chk("t2_lat",    32'(lat),         32'(1 + 9 + SQ_LAT));
    chk("t2_mag",    32'(bus.mag_raw), 40);
    chk("t2_result", 32'(bus.result),  40);

    // 5x5 sign extremes: gx = 25 * -16256 = -406400
    setup_extreme();
    launch(OP_GRAD, 2'b11);
    wait_done(lat);
    chk("t3_lat",    32'(lat),         32'(1 + 25 + SQ_LAT));
    chk("t3_mag",    32'(bus.mag_raw), 406400);
    chk("t3_result", 32'(bus.result),  255);

    // illegal op code, then a legal job clears op_err
    launch(3'b010, 2'b01);
    wait_done(lat);
    chk("t4_lat",    32'(lat),         1);
    chk("t4_op_err", 32'(bus.op_err),  1);
    chk("t4_result", 32'(bus.result),  0);
    chk("t4_mag",    32'(bus.mag_raw), 0);
    setup_t1();
    launch(OP_GRAD, 2'b00);
    wait_done(lat);
    chk("t4_clear_err", 32'(bus.op_err),  0);
    chk("t4_next_mag",  32'(bus.mag_raw), 32'(T1_MAG));

    // start and new data mid-job are ignored
    setup_sobel();
    launch(OP_GRAD, 2'b01);
    tick(4);
    clear_mats();
    bus.matrix_size = 2'b00;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(lat);
    chk("t5_lat",    32'(lat),         32'(1 + 9 + SQ_LAT));
    chk("t5_mag",    32'(bus.mag_raw), 40);
    chk("t5_result", 32'(bus.result),  40);
    tick(3);
    chk("t5_no_queue", 32'(bus.busy),  0);

    // reset mid-job aborts without done and clears outputs
    setup_t1();
    launch(OP_GRAD, 2'b00);
    tick(9);
    reset = 1'b1;
    tick();
    chk("t6_busy",   32'(bus.busy),    0);
    chk("t6_done",   32'(bus.done),    0);
    chk("t6_result", 32'(bus.result),  0);
    chk("t6_mag",    32'(bus.mag_raw), 0);
    chk("t6_op_err", 32'(bus.op_err),  0);
    reset = 1'b0;
    seen  = 0;
    repeat (40) begin
      tick();
      if (bus.done === 1'b1) seen++;
    end
    chk("t6_no_done", 32'(seen), 0);
    setup_extreme();
    launch(OP_GRAD, 2'b11);
    wait_done(lat);
    chk("t6_lat",    32'(lat),         32'(1 + 25 + SQ_LAT));
    chk("t6_result", 32'(bus.result),  255);
    chk("t6_mag2",   32'(bus.mag_raw), 406400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
